// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector and the IF->ID bundle layout.
package cpu_defs;

    localparam logic [31:0] RESET_PC        = 32'h1c000000;
    localparam int          FS_TO_DS_BUS_WD = 65;

    // IF->ID bundle field offsets: {adef, pc, inst}
    localparam int BUS_INST_LSB = 0;
    localparam int BUS_PC_LSB   = 32;
    localparam int BUS_ADEF_BIT = 64;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage with a one-entry skid buffer for SRAM read data.
// Optional macro IF_ADEF_EN: flag misaligned fetch addresses (adef) instead of issuing them.
module if_stage
    import cpu_defs::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       br_valid,
    input  logic [31:0]                br_target,
    input  logic                       ds_allow_in,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic [31:0] r_fs_pc;
    logic        r_fs_valid;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic        w_fs_allow_in;
    logic        w_handshake;
    logic        w_capture;
    logic        w_fs_adef;
    logic [31:0] w_inst;

    assign w_seq_pc      = r_fs_pc + 32'd4;
    assign w_nextpc      = br_valid ? br_target : w_seq_pc;
    assign w_fs_allow_in = !r_fs_valid | (ds_allow_in & r_fs_valid) | br_valid;

    assign fs_to_ds_valid = r_fs_valid & !br_valid;
    assign w_handshake    = fs_to_ds_valid & ds_allow_in;
    // Only the first stall cycle still sees the fetched word on rdata.
    assign w_capture      = r_fs_valid & !ds_allow_in & !r_buf_valid & !br_valid;

`ifdef IF_ADEF_EN
    logic w_next_misalign;
    assign w_next_misalign = (w_nextpc[1:0] != 2'b00);
    assign w_fs_adef       = (r_fs_pc[1:0] != 2'b00);
    assign inst_sram_en    = resetn & w_fs_allow_in & !w_next_misalign;
`else
    assign w_fs_adef       = 1'b0;
    assign inst_sram_en    = resetn & w_fs_allow_in;
`endif

    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;
    assign inst_sram_addr  = w_nextpc;

    assign w_inst = w_fs_adef   ? 32'h0000_0000 :
                    r_buf_valid ? r_inst_buf    : inst_sram_rdata;

    assign fs_to_ds_bus[BUS_ADEF_BIT]      = w_fs_adef;
    assign fs_to_ds_bus[BUS_PC_LSB +: 32]  = r_fs_pc;
    assign fs_to_ds_bus[BUS_INST_LSB +: 32] = w_inst;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fs_pc    <= RESET_PC - 32'd4;
            r_fs_valid <= 1'b0;
        end else if (w_fs_allow_in) begin
            r_fs_pc    <= w_nextpc;
            r_fs_valid <= 1'b1;
        end
    end

    // Clear wins over capture so a redirect never leaves a stale word behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'h0000_0000;
        end else if (w_handshake | br_valid) begin
            r_buf_valid <= 1'b0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_inst_buf  <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed, scoreboard-checked bench for if_stage; build with IF_ADEF_EN to cover the adef path.
module tb_if_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_valid;
    logic [31:0] br_target;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [64:0] sb_q[$];

    if_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .ds_allow_in    (ds_allow_in),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    function automatic logic [64:0] bundle(input logic adef, input logic [31:0] pc,
                                           input logic [31:0] inst);
        return {adef, pc, inst};
    endfunction

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM model: data one cycle after a request, garbage when not requested.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_of(inst_sram_addr);
        else
            inst_sram_rdata <= $urandom;
    end

    // Handover monitor: every handshake pops one expected bundle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && fs_to_ds_valid && ds_allow_in) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL hs_unexpected: got %h expected no handover", fs_to_ds_bus);
            end else begin
                logic [64:0] exp_bus;
                exp_bus = sb_q.pop_front();
                $display("[TB] handover pc=%h inst=%h adef=%0b",
                         fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], fs_to_ds_bus[64]);
                check("hs_bus", fs_to_ds_bus, exp_bus);
            end
        end
    end

    task automatic cyc(input logic br, input logic [31:0] tgt, input logic allow);
        @(posedge clk);
        #1;
        br_valid    = br;
        br_target   = tgt;
        ds_allow_in = allow;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic exp_adef_en;

    initial begin
`ifdef IF_ADEF_EN
        exp_adef_en = 1'b1;
`else
        exp_adef_en = 1'b0;
`endif
        resetn      = 1'b0;
        br_valid    = 1'b0;
        br_target   = 32'h0;
        ds_allow_in = 1'b1;

        // Reset state
        repeat (2) sample();
        check("rst_en",    {64'h0, inst_sram_en},   65'h0);
        check("rst_valid", {64'h0, fs_to_ds_valid}, 65'h0);
        check("rst_pc",    {33'h0, fs_to_ds_bus[63:32]}, {33'h0, 32'h1bfffffc});
        check("rst_we",    {61'h0, inst_sram_we},   65'h0);
        check("rst_wdata", {33'h0, inst_sram_wdata}, 65'h0);

        // Release: sequential fetch from the reset vector
        cyc(1'b0, 32'h0, 1'b1);
        resetn = 1'b1;
        sb_q.push_back(bundle(1'b0, 32'h1c000000, inst_of(32'h1c000000)));
        sample();
        check("s1_addr0",  {33'h0, inst_sram_addr}, {33'h0, 32'h1c000000});
        check("s1_en0",    {64'h0, inst_sram_en},   65'h1);
        check("s1_valid0", {64'h0, fs_to_ds_valid}, 65'h0);

        cyc(1'b0, 32'h0, 1'b1);
        sb_q.push_back(bundle(1'b0, 32'h1c000004, inst_of(32'h1c000004)));
        sample();
        check("s1_addr1",  {33'h0, inst_sram_addr}, {33'h0, 32'h1c000004});
        check("s1_valid1", {64'h0, fs_to_ds_valid}, 65'h1);

        cyc(1'b0, 32'h0, 1'b1);
        sb_q.push_back(bundle(1'b0, 32'h1c000008, inst_of(32'h1c000008)));
        sample();
        check("s1_addr2", {33'h0, inst_sram_addr}, {33'h0, 32'h1c000008});

        // Three-cycle stall at 1c000008 while SRAM data wanders
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            sample();
            check("s2_en",  {64'h0, inst_sram_en}, 65'h0);
            check("s2_bus", fs_to_ds_bus, bundle(1'b0, 32'h1c000008, inst_of(32'h1c000008)));
        end
        cyc(1'b0, 32'h0, 1'b1);
        sample();
        check("s2_resume_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c00000c});

        // Unstalled redirect: 1c00000c is discarded
        cyc(1'b1, 32'h1c000100, 1'b1);
        sample();
        check("s3_valid", {64'h0, fs_to_ds_valid}, 65'h0);
        check("s3_addr",  {33'h0, inst_sram_addr}, {33'h0, 32'h1c000100});
        check("s3_en",    {64'h0, inst_sram_en},   65'h1);

        cyc(1'b0, 32'h0, 1'b1);
        sb_q.push_back(bundle(1'b0, 32'h1c000100, inst_of(32'h1c000100)));
        sample();
        check("s3_next_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c000104});

        // Redirect during a stall with the skid buffer full
        cyc(1'b0, 32'h0, 1'b0);
        sample();
        cyc(1'b0, 32'h0, 1'b0);
        sample();
        check("s4_buf_bus", fs_to_ds_bus, bundle(1'b0, 32'h1c000104, inst_of(32'h1c000104)));
        cyc(1'b1, 32'h1c000100, 1'b0);
        sample();
        check("s4_valid", {64'h0, fs_to_ds_valid}, 65'h0);
        check("s4_addr",  {33'h0, inst_sram_addr}, {33'h0, 32'h1c000100});
        check("s4_en",    {64'h0, inst_sram_en},   65'h1);
        cyc(1'b0, 32'h0, 1'b1);
        sb_q.push_back(bundle(1'b0, 32'h1c000100, inst_of(32'h1c000100)));
        sample();
        check("s4_inst", fs_to_ds_bus, bundle(1'b0, 32'h1c000100, inst_of(32'h1c000100)));

        // Reset pulse in the middle of a buffered stall
        cyc(1'b0, 32'h0, 1'b0);
        sample();
        cyc(1'b0, 32'h0, 1'b0);
        sample();
        check("s5_pre_valid", {64'h0, fs_to_ds_valid}, 65'h1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("s5_rst_valid", {64'h0, fs_to_ds_valid}, 65'h0);
        check("s5_rst_en",    {64'h0, inst_sram_en},   65'h0);
        cyc(1'b0, 32'h0, 1'b1);
        resetn = 1'b1;
        sb_q.push_back(bundle(1'b0, 32'h1c000000, inst_of(32'h1c000000)));
        sample();
        check("s5_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c000000});
        check("s5_en",   {64'h0, inst_sram_en},   65'h1);
        cyc(1'b0, 32'h0, 1'b1);
        sample();

        // Misaligned redirect target
        cyc(1'b1, 32'h1c000102, 1'b1);
        sample();
        check("s6_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c000102});
        check("s6_en",   {64'h0, inst_sram_en},   {64'h0, !exp_adef_en});
        cyc(1'b0, 32'h0, 1'b1);
        if (exp_adef_en)
            sb_q.push_back(bundle(1'b1, 32'h1c000102, 32'h0));
        else
            sb_q.push_back(bundle(1'b0, 32'h1c000102, inst_of(32'h1c000102)));
        sample();
        check("s6_next_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c000106});
        check("s6_next_en",   {64'h0, inst_sram_en},   {64'h0, !exp_adef_en});
        cyc(1'b0, 32'h0, 1'b0);
        sample();

        check("sb_drained", {33'h0, 32'(sb_q.size())}, 65'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL expose these ports, one per line (name, direction, width, meaning).
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- br_valid  in  1  one-cycle redirect request from decode.
- br_target  in  32  redirect PC.
- ds_allow_in  in  1  decode can accept this cycle.
- fs_to_ds_valid  out  1  fetch bundle valid.
- fs_to_ds_bus  out  65  {adef[64], pc[63:32], inst[31:0]}.
- inst_sram_en  out  1  SRAM read request.
- inst_sram_we  out  4  byte write enables, tied 4'b0.
- inst_sram_addr  out  32  fetch address, equal to nextpc.
- inst_sram_wdata  out  32  tied 32'b0.
- inst_sram_rdata  in  32  read data, valid one cycle after request.

Function
REQ-002 seq_pc SHALL be fs_pc+4, modulo 2^32; nextpc SHALL be br_target when br_valid, else seq_pc.
REQ-003 fs_allow_in SHALL be !fs_valid | (ds_allow_in & fs_valid) | br_valid.
REQ-004 inst_sram_en SHALL be 1 only when out of reset and fs_allow_in.
REQ-005 When fs_allow_in, the block SHALL load fs_pc<=nextpc and fs_valid<=1 on the clock edge; otherwise it SHALL hold both.
REQ-006 Fetch latency SHALL be exactly one cycle: an address issued in cycle N appears in the bus inst field in cycle N+1.
REQ-007 fs_to_ds_valid SHALL be fs_valid & !br_valid; a handshake occurs when fs_to_ds_valid & ds_allow_in.
REQ-008 On br_valid, the instruction currently in IF SHALL be discarded, and br_target SHALL be fetched next cycle, even if decode is stalling.
REQ-009 Skid buffer: on the first stall cycle (fs_valid & !ds_allow_in & !buf_valid & !br_valid), the block SHALL capture inst_sram_rdata into inst_buf and set buf_valid.
REQ-010 The inst field SHALL be inst_buf when buf_valid, else inst_sram_rdata.
REQ-011 buf_valid SHALL clear on handshake or br_valid; a simultaneous capture and clear SHALL resolve to clear.
REQ-012 The bus pc field SHALL be fs_pc, and the bus SHALL remain stable while stalled.

Reset
REQ-013 While resetn=0, the block SHALL hold: fs_pc=32'h1bfffffc, fs_valid=0, buf_valid=0, inst_buf=0, fs_to_ds_valid=0, inst_sram_en=0.
REQ-014 In the first cycle after release, the block SHALL issue a request at 32'h1c000000; an asserted reset mid-stall SHALL discard all in-flight state.

Configuration
REQ-015 With IF_ADEF_EN defined:
- a nextpc where nextpc[1:0]!=0 SHALL suppress inst_sram_en;
- the block SHALL still advance fs_pc;
- the bundle SHALL carry adef=1 and inst=32'h0.
REQ-016 Without IF_ADEF_EN, bit 64 SHALL be tied 0 and misaligned addresses SHALL be issued unchanged.

Structure
REQ-017 The shared package cpu_defs SHALL hold RESET_PC (32'h1c000000), FS_TO_DS_BUS_WD (65) and the bus field offsets.
REQ-018 The stage SHALL be implemented as one module with no sub-module; the skid buffer is inline.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release with ds_allow_in=1 -> addresses 1c000000, 1c000004, 1c000008 on consecutive cycles; valid starts the cycle after the first request.
- Hold ds_allow_in=0 for 3 cycles at pc 1c000008 while SRAM rdata changes -> bus holds pc 1c000008 and the originally fetched inst; en=0 throughout.
- br_valid with br_target=1c000100 while unstalled -> next address 1c000100; fs_to_ds_valid=0 that cycle; next bundle pc=1c000100.
- br_valid during a stall with buf_valid=1 -> buffer cleared, 1c000100 fetched, stale inst never handed over.
- resetn pulsed low mid-stall -> valid=0 immediately; refetch from 1c000000.
- With IF_ADEF_EN, br_target=1c000102 -> en=0; bundle adef=1, inst=0, pc=1c000102; next address 1c000106.
